// File: rtl/layer_ctrl.sv
// layer_ctrl: sequencer for one conv->activation->pool layer instance.
//   On start it collects K*K weights plus a bias byte from a byte stream. It then
//   streams the W*W feature map from a 1-cycle-latency read memory into the layer
//   datapath, writes each pooled result to the result memory, and pulses done.
// Ports:
//   clk, global_rst              clock (rising edge), async active-low reset
//   start                        1-cycle run request, honoured in IDLE only
//   wt_in, wt_valid              weight/bias byte stream, used in LOAD_W only
//   img_rd_en, img_addr          feature-map read port (registered)
//   img_rd_data                  read data, valid the cycle after img_rd_en
//   layer_clr, layer_ce          layer datapath clear / clock enable (registered)
//   layer_input                  pixel into the layer (registered)
//   layer_weight, layer_bias     held weights (byte i at [i*dataWidth +: dataWidth]) and bias
//   layer_data_out, layer_valid_op  pooled result from the layer
//   res_we, res_addr, res_data   result write port, combinational pass-through
//   busy, done, err              status: running, 1-cycle completion, sticky drain timeout
module layer_ctrl #(
  parameter int unsigned dataWidth = 8,
  parameter int unsigned W         = 6,
  parameter int unsigned K         = 3,
  parameter int unsigned P         = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic                      clk,
  input  logic                      global_rst,
  input  logic                      start,
  input  logic [dataWidth-1:0]      wt_in,
  input  logic                      wt_valid,
  output logic                      img_rd_en,
  output logic [ADDR_W-1:0]         img_addr,
  input  logic [dataWidth-1:0]      img_rd_data,
  output logic                      layer_clr,
  output logic                      layer_ce,
  output logic [dataWidth-1:0]      layer_input,
  output logic [K*K*dataWidth-1:0]  layer_weight,
  output logic [dataWidth-1:0]      layer_bias,
  input  logic [dataWidth-1:0]      layer_data_out,
  input  logic                      layer_valid_op,
  output logic                      res_we,
  output logic [ADDR_W-1:0]         res_addr,
  output logic [dataWidth-1:0]      res_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned NW        = K * K;
  localparam int unsigned NPIX      = W * W;
  localparam int unsigned N_SIDE    = (W - K + 1) / P;
  localparam int unsigned N_OUT     = N_SIDE * N_SIDE;
  localparam int unsigned WT_CNT_W  = $clog2(NW + 1);
  localparam int unsigned PIX_CNT_W = $clog2(NPIX + 1);
  localparam int unsigned RES_CNT_W = $clog2(N_OUT + 1);
  localparam int unsigned DRN_CNT_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [WT_CNT_W-1:0]      wt_cnt_q, wt_cnt_d;
  logic [PIX_CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [RES_CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic [DRN_CNT_W-1:0]     drn_cnt_q, drn_cnt_d;
  logic [NW*dataWidth-1:0]  weight_q, weight_d;
  logic [dataWidth-1:0]     bias_q, bias_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     ce_q, ce_d;
  logic [dataWidth-1:0]     input_q, input_d;
  logic                     clr_q, clr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     active_q, active_d;
  logic                     res_accept;

  // Results are accepted only while the layer is being fed and slots remain.
  assign active_q   = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign res_accept = layer_valid_op && active_q && (res_cnt_q < RES_CNT_W'(N_OUT));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d   = state_q;
    wt_cnt_d  = wt_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    res_cnt_d = res_accept ? res_cnt_q + RES_CNT_W'(1) : res_cnt_q;
    drn_cnt_d = drn_cnt_q;
    weight_d  = weight_q;
    bias_d    = bias_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_W;
          wt_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      S_LOAD_W: begin
        if (wt_valid) begin
          if (wt_cnt_q == WT_CNT_W'(NW)) begin
            bias_d    = wt_in;
            state_d   = S_STREAM;
            rd_cnt_d  = '0;
            res_cnt_d = '0;
          end else begin
            for (int unsigned i = 0; i < NW; i++) begin
              if (wt_cnt_q == WT_CNT_W'(i)) weight_d[i*dataWidth +: dataWidth] = wt_in;
            end
            wt_cnt_d = wt_cnt_q + WT_CNT_W'(1);
          end
        end
      end
      S_STREAM: begin
        if (rd_cnt_q == PIX_CNT_W'(NPIX - 1)) begin
          state_d   = S_DRAIN;
          drn_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + PIX_CNT_W'(1);
        end
      end
      S_DRAIN: begin
        drn_cnt_d = drn_cnt_q + DRN_CNT_W'(1);
        if (res_cnt_d == RES_CNT_W'(N_OUT)) begin
          state_d = S_DONE;
        end else if (drn_cnt_q == DRN_CNT_W'(DRAIN_MAX - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with state_q.
    active_d   = (state_d == S_STREAM) || (state_d == S_DRAIN);
    rd_en_d    = (state_d == S_STREAM);
    addr_d     = rd_en_d ? ADDR_W'(rd_cnt_d) : '0;
    rd_valid_d = rd_en_q;
    // Pixel pipe: memory data lands one cycle after the read, then one register stage.
    // Once in DRAIN and the pipe is empty, keep clocking zeros through to flush the layer.
    ce_d       = active_d && (rd_valid_q || (state_q == S_DRAIN));
    input_d    = (active_d && rd_valid_q) ? img_rd_data : '0;
    clr_d      = !active_d;
    busy_d     = (state_d == S_LOAD_W) || active_d;
    done_d     = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state_q    <= S_IDLE;
      wt_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      res_cnt_q  <= '0;
      drn_cnt_q  <= '0;
      weight_q   <= '0;
      bias_q     <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      ce_q       <= 1'b0;
      input_q    <= '0;
      clr_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wt_cnt_q   <= wt_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      res_cnt_q  <= res_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      ce_q       <= ce_d;
      input_q    <= input_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign img_rd_en    = rd_en_q;
  assign img_addr     = addr_q;
  assign layer_clr    = clr_q;
  assign layer_ce     = ce_q;
  assign layer_input  = input_q;
  assign layer_weight = weight_q;
  assign layer_bias   = bias_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  // Result write port passes straight through from the layer.
  assign res_we   = res_accept;
  assign res_addr = res_accept ? ADDR_W'(res_cnt_q) : '0;
  assign res_data = res_accept ? layer_data_out : '0;

endmodule

// File: tb/tb_layer_ctrl.sv
// Scoreboard bench for layer_ctrl with a feature-map memory and a behavioural
// conv/relu/max-pool layer model.
module tb_layer_ctrl;
  localparam int DW = 8, W = 6, K = 3, P = 2, AW = 16, DRAIN_MAX = 64;
  localparam int NW = K * K, NPIX = W * W, NS = (W - K + 1) / P, N_OUT = NS * NS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               global_rst, start, wt_valid;
  logic [DW-1:0]      wt_in;
  logic               img_rd_en;
  logic [AW-1:0]      img_addr;
  logic [DW-1:0]      img_rd_data;
  logic               layer_clr, layer_ce;
  logic [DW-1:0]      layer_input;
  logic [NW*DW-1:0]   layer_weight;
  logic [DW-1:0]      layer_bias, layer_data_out;
  logic               layer_valid_op, model_valid, stray_valid;
  logic               res_we, busy, done, err;
  logic [AW-1:0]      res_addr;
  logic [DW-1:0]      res_data;

  layer_ctrl #(.dataWidth(DW), .W(W), .K(K), .P(P), .ADDR_W(AW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .global_rst(global_rst), .start(start), .wt_in(wt_in), .wt_valid(wt_valid),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
    .layer_clr(layer_clr), .layer_ce(layer_ce), .layer_input(layer_input),
    .layer_weight(layer_weight), .layer_bias(layer_bias),
    .layer_data_out(layer_data_out), .layer_valid_op(layer_valid_op),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  logic [DW-1:0] img_mem [NPIX];
  logic [DW-1:0] wts [NW];
  logic [DW-1:0] bias_v;

  // Reference: conv + relu (clamped to 8 bits) then PxP max pool for output o.
  function automatic logic [DW-1:0] pool_out(input int o, input logic [DW-1:0] pix [NPIX],
                                             input logic [DW-1:0] w [NW], input logic [DW-1:0] b);
    int best, s, r, c;
    best = 0;
    for (int py = 0; py < P; py++) begin
      for (int px = 0; px < P; px++) begin
        r = (o / NS) * P + py;
        c = (o % NS) * P + px;
        s = int'(b);
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += int'(w[i*K+j]) * int'(pix[(r+i)*W + c + j]);
        if (s > 255) s = 255;
        if (s > best) best = s;
      end
    end
    return DW'(best);
  endfunction

  // Feature-map memory, one-cycle read latency.
  always @(posedge clk) if (img_rd_en) img_rd_data <= img_mem[img_addr[5:0]];

  // Layer model: captures the first NPIX pixels, then emits N_OUT results every other cycle.
  logic [DW-1:0] rx_pix [NPIX];
  logic [DW-1:0] rx_w [NW];
  int            lcount, emit_idx;
  logic          tick;
  bit            valid_mode;

  always_comb for (int i = 0; i < NW; i++) rx_w[i] = layer_weight[i*DW +: DW];
  assign layer_valid_op = model_valid | stray_valid;

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (layer_clr) begin
      lcount <= 0; emit_idx <= 0; tick <= 1'b0;
    end else begin
      if (layer_ce) begin
        if (lcount < NPIX) rx_pix[lcount] <= layer_input;
        lcount <= lcount + 1;
      end
      if (valid_mode && lcount >= NPIX && emit_idx < N_OUT) begin
        tick <= ~tick;
        if (tick) begin
          model_valid    <= 1'b1;
          layer_data_out <= pool_out(emit_idx, rx_pix, rx_w, layer_bias);
          emit_idx       <= emit_idx + 1;
        end
      end
    end
  end

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t sb_q [$];
  wr_t mon_e;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_addr, first_rd, last_rd, first_ce, ce_idx, wr_count, last_wr, done_count, done_cycle;

  task automatic clear_mon();
    exp_addr = 0; first_rd = -1; last_rd = -1; first_ce = -1; ce_idx = 0;
    wr_count = 0; last_wr = -1; done_count = 0; done_cycle = -1;
  endtask

  // Monitor: scoreboard pops on writes, checks read order and pixel delivery.
  always @(negedge clk) begin
    if (res_we) begin
      if (sb_q.size() == 0) chk("res_unexpected", 32'(res_we), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk("res_addr", 32'(res_addr), 32'(mon_e.addr));
        chk("res_data", 32'(res_data), 32'(mon_e.data));
        wr_count++;
        last_wr = cyc;
      end
    end
    if (done) begin done_count++; done_cycle = cyc; end
    if (img_rd_en) begin
      if (exp_addr == 0) first_rd = cyc;
      chk("img_addr", 32'(img_addr), 32'(exp_addr));
      exp_addr++;
      last_rd = cyc;
    end
    if (layer_ce) begin
      if (ce_idx == 0) first_ce = cyc;
      if (ce_idx < NPIX) chk("pixel", 32'(layer_input), 32'(img_mem[ce_idx]));
      else chk("flush_zero", 32'(layer_input), 32'd0);
      ce_idx++;
    end
  end

  task automatic load_weights();
    for (int i = 0; i <= NW; i++) begin
      if (i == NW) begin
        wt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      wt_valid = 1'b1;
      wt_in    = (i < NW) ? wts[i] : bias_v;
      @(posedge clk); #1;
    end
    wt_valid = 1'b0;
  endtask

  task automatic check_weights(input string tag);
    for (int i = 0; i < NW; i++) chk(tag, 32'(layer_weight[i*DW +: DW]), 32'(wts[i]));
    chk({tag, "_bias"}, 32'(layer_bias), 32'(bias_v));
  endtask

  task automatic do_run(input bit to_mode, input bit poke);
    bit got_done;
    sb_q.delete();
    if (!to_mode)
      for (int o = 0; o < N_OUT; o++) sb_q.push_back({AW'(o), pool_out(o, img_mem, wts, bias_v)});
    valid_mode = !to_mode;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("start_clears_err", 32'(err), 32'd0);
    chk("load_clr", 32'(layer_clr), 32'd1);
    load_weights();
    chk("stream_entry_rd", 32'(img_rd_en), 32'd1);
    chk("stream_entry_clr", 32'(layer_clr), 32'd0);
    check_weights("weight");
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1; wt_valid = 1'b1; wt_in = 8'hA5;
      @(posedge clk); #1 start = 1'b0; wt_valid = 1'b0;
    end
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; break; end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("reads_issued", 32'(exp_addr), 32'(NPIX));
    chk("first_ce_lat", 32'(first_ce - first_rd), 32'd2);
    chk("ce_cycles", 32'(ce_idx >= NPIX), 32'd1);
    chk("done_pulses", 32'(done_count), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_clr", 32'(layer_clr), 32'd1);
    check_weights("weight_hold");
    if (to_mode) begin
      chk("timeout_writes", 32'(wr_count), 32'd0);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_lat", 32'(done_cycle - last_rd), 32'(1 + DRAIN_MAX));
    end else begin
      chk("write_count", 32'(wr_count), 32'(N_OUT));
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("done_lat", 32'(done_cycle - last_wr), 32'd1);
      chk("run_err", 32'(err), 32'd0);
    end
  endtask

  initial begin
    global_rst = 1'b0; start = 1'b0; wt_valid = 1'b0; wt_in = '0;
    stray_valid = 1'b0; valid_mode = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(img_rd_en), 32'd0);
    chk("rst_clr", 32'(layer_clr), 32'd1);
    chk("rst_ce", 32'(layer_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_weight", 32'(layer_weight == '0), 32'd1);
    chk("rst_bias", 32'(layer_bias), 32'd0);
    global_rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of STREAM abandons the run.
    for (int i = 0; i < NPIX; i++) img_mem[i] = 8'd1;
    for (int i = 0; i < NW; i++) wts[i] = 8'd1;
    bias_v = 8'd0;
    valid_mode = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    load_weights();
    repeat (10) @(posedge clk);
    #1;
    chk("mid_stream_rd", 32'(img_rd_en), 32'd1);
    global_rst = 1'b0;
    #1;
    chk("abort_rd_en", 32'(img_rd_en), 32'd0);
    chk("abort_clr", 32'(layer_clr), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_weight", 32'(layer_weight == '0), 32'd1);
    @(posedge clk); #1 global_rst = 1'b1;
    clear_mon();
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_count), 32'd0);

    // All-ones image, unit weights, zero bias: every pooled result is 9.
    do_run(1'b0, 1'b0);

    // Weights 1..9, bias 5, random small pixels; start/wt_valid poked mid-stream.
    for (int i = 0; i < NPIX; i++) img_mem[i] = DW'($urandom_range(0, 3));
    for (int i = 0; i < NW; i++) wts[i] = DW'(i + 1);
    bias_v = 8'h05;
    do_run(1'b0, 1'b1);

    // wt_valid and a stray result in IDLE are ignored.
    #1 wt_valid = 1'b1; wt_in = 8'hEE; stray_valid = 1'b1;
    #1 chk("idle_stray_drop", 32'(res_we), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 wt_valid = 1'b0; stray_valid = 1'b0;
    chk("idle_no_busy", 32'(busy), 32'd0);
    check_weights("idle_weight");

    // Layer never answers: drain timeout raises err.
    do_run(1'b1, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    // Fresh run after timeout clears err.
    for (int i = 0; i < NPIX; i++) img_mem[i] = DW'((i * 7) % 5);
    for (int i = 0; i < NW; i++) wts[i] = DW'(i % 3);
    bias_v = 8'h02;
    do_run(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
